// File: rtl/riscv_alu_pkg.sv
// Shared ALU-side types: operand/result width, op-code width, requester IDs
// and the operand/op bundle handed to the shared ALU.
package riscv_alu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ALU_OPW = 5;

  typedef enum logic {
    REQ_EXE = 1'b0,
    REQ_BRU = 1'b1
  } req_id_t;

  typedef struct packed {
    logic [XLEN-1:0]    src0;
    logic [XLEN-1:0]    src1;
    logic [ALU_OPW-1:0] op;
  } alu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant plus last-grant history.
module rr_arb2
  import riscv_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output req_id_t    grant
);

  req_id_t last_grant_q, last_grant_d;

  // Lone requester wins; on contention (or idle) favour the one not served last.
  always_comb begin
    grant = (last_grant_q == REQ_EXE) ? REQ_BRU : REQ_EXE;
    if (valid == 2'b01) grant = REQ_EXE;
    else if (valid == 2'b10) grant = REQ_BRU;
  end

  // History only moves on a real handshake.
  always_comb begin
    last_grant_d = accept ? grant : last_grant_q;
  end

  // History register; reset favours requester 0 at the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= REQ_BRU;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between the execute and branch/address paths:
// round-robin accept into an operand stage that drives the ALU, then a result
// stage returned over a valid/ready response channel.
module alu_share_arb
  import riscv_alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_src0,
  input  logic [XLEN-1:0] req0_src1,
  input  logic [OPW-1:0]  req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_src0,
  input  logic [XLEN-1:0] req1_src1,
  input  logic [OPW-1:0]  req1_op,
  output logic [XLEN-1:0] alu_src0,
  output logic [XLEN-1:0] alu_src1,
  output logic [OPW-1:0]  alu_op,
  input  logic [XLEN-1:0] alu_res,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [XLEN-1:0] resp_res
);

  req_id_t         grant;
  logic            s1_ready, s2_ready, accept, s1_xfer;
  alu_req_t        sel_req;
  alu_req_t        s1_req_q, s1_req_d;
  logic            s1_valid_q, s1_valid_d;
  req_id_t         s1_id_q, s1_id_d;
  logic            resp_valid_q, resp_valid_d;
  req_id_t         resp_id_q, resp_id_d;
  logic [XLEN-1:0] resp_res_q, resp_res_d;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  // Handshake and stage-advance conditions; ready is masked during reset.
  always_comb begin
    s2_ready   = !resp_valid_q || resp_ready;
    s1_ready   = !s1_valid_q || s2_ready;
    s1_xfer    = s1_valid_q && s2_ready;
    accept     = s1_ready && (req0_valid || req1_valid);
    req0_ready = s1_ready && !rst && (grant == REQ_EXE);
    req1_ready = s1_ready && !rst && (grant == REQ_BRU);
  end

  // Operand stage: load the granted bundle, otherwise hold so the ALU inputs stay quiet.
  always_comb begin
    sel_req    = (grant == REQ_BRU) ? '{src0: req1_src0, src1: req1_src1, op: req1_op}
                                    : '{src0: req0_src0, src1: req0_src1, op: req0_op};
    s1_req_d   = s1_req_q;
    s1_id_d    = s1_id_q;
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_req_d   = sel_req;
      s1_id_d    = grant;
      s1_valid_d = 1'b1;
    end else if (s1_xfer) begin
      s1_valid_d = 1'b0;
    end
  end

  // Result stage: capture the ALU output on transfer, drop valid on drain.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_res_d   = resp_res_q;
    if (s1_xfer) begin
      resp_valid_d = 1'b1;
      resp_id_d    = s1_id_q;
      resp_res_d   = alu_res;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_req_q     <= '0;
      s1_id_q      <= REQ_EXE;
      s1_valid_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= REQ_EXE;
      resp_res_q   <= '0;
    end else begin
      s1_req_q     <= s1_req_d;
      s1_id_q      <= s1_id_d;
      s1_valid_q   <= s1_valid_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_res_q   <= resp_res_d;
    end
  end

  assign alu_src0   = s1_req_q.src0;
  assign alu_src1   = s1_req_q.src1;
  assign alu_op     = s1_req_q.op;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_res   = resp_res_q;

endmodule
